// File: rtl/reduction_stream_acc.sv
// Streaming reduction: folds a packet of WIDTH-bit words into one AND/OR/XOR bit (optionally inverted).
// Latency: result valid one cycle after the closing beat is accepted; results are held until out_ready.
// Backpressure: in_ready = !out_valid || out_ready. Optional popcount output enabled by REDUCE_POPCNT_EN.
module reduction_stream_acc #(
   parameter  int WIDTH     = 8,
   parameter  int MAX_WORDS = 16,
   localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic [2:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_result,
   output logic [CNT_W-1:0] out_words,
   output logic             out_ovf,
   output logic             out_err
`ifdef REDUCE_POPCNT_EN
   ,output logic [CNT_W+$clog2(WIDTH+1)-1:0] out_ones
`endif
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;
   logic             valid_q, valid_d;
   logic             res_q, res_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   logic             beat;
   logic             start;
   logic [2:0]       eff_mode;
   logic             fold_in;
   logic             acc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             close;
   logic             inv;
   logic             illegal;

   assign in_ready = !valid_q || out_ready;
   assign beat     = in_valid && in_ready;
   assign start    = (state_q == IDLE);
   // Mode is taken live on the first word of a packet and from the latch afterwards.
   assign eff_mode = start ? mode : mode_q;
   assign inv      = (eff_mode == 3'd3) || (eff_mode == 3'd4) || (eff_mode == 3'd5);
   assign illegal  = (eff_mode == 3'd6) || (eff_mode == 3'd7);
   assign cnt_nxt  = (start ? '0 : cnt_q) + CNT_W'(1);
   // A packet ends on in_last or when it reaches the word limit.
   assign close    = beat && (in_last || (cnt_nxt == CNT_W'(MAX_WORDS)));

   // Fold the current word into the running accumulator, starting from the op identity.
   always_comb begin
      fold_in = start ? ((eff_mode == 3'd0) || (eff_mode == 3'd3)) : acc_q;
      acc_nxt = fold_in | (|in_data);
      case (eff_mode)
         3'd0, 3'd3: acc_nxt = fold_in & (&in_data);
         3'd2, 3'd5: acc_nxt = fold_in ^ (^in_data);
         default:    acc_nxt = fold_in | (|in_data);
      endcase
   end

   // Next-state logic for the packet FSM and the result registers.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      valid_d = valid_q;
      res_d   = res_q;
      words_d = words_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (beat) begin
         if (close) begin
            state_d = IDLE;
            acc_d   = 1'b0;
            cnt_d   = '0;
            valid_d = 1'b1;
            res_d   = acc_nxt ^ inv;
            words_d = cnt_nxt;
            ovf_d   = !in_last;
            err_d   = illegal;
         end else begin
            state_d = ACC;
            acc_d   = acc_nxt;
            cnt_d   = cnt_nxt;
            mode_d  = eff_mode;
         end
      end
   end

   // State and result registers; reset discards any packet in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= 3'd0;
         valid_q <= 1'b0;
         res_q   <= 1'b0;
         words_q <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         words_q <= words_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_result = res_q;
   assign out_words  = words_q;
   assign out_ovf    = ovf_q;
   assign out_err    = err_q;

`ifdef REDUCE_POPCNT_EN
   localparam int BIT_W = $clog2(WIDTH + 1);
   localparam int POP_W = CNT_W + BIT_W;

   logic [POP_W-1:0] ones_q, ones_d, ones_nxt;
   logic [POP_W-1:0] res_ones_q, res_ones_d;

   function automatic logic [BIT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
      logic [BIT_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + BIT_W'(v[i]);
      end
      return n;
   endfunction

   assign ones_nxt = (start ? '0 : ones_q) + POP_W'(popcnt(in_data));

   // Running count of set bits, transferred to the result register on close.
   always_comb begin
      ones_d     = ones_q;
      res_ones_d = res_ones_q;
      if (beat) begin
         if (close) begin
            ones_d     = '0;
            res_ones_d = ones_nxt;
         end else begin
            ones_d     = ones_nxt;
         end
      end
   end

   // Popcount registers share the reset and load timing of the other results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_q     <= '0;
         res_ones_q <= '0;
      end else begin
         ones_q     <= ones_d;
         res_ones_q <= res_ones_d;
      end
   end

   assign out_ones = res_ones_q;
`endif

endmodule

// File: tb/tb_reduction_stream_acc.sv
// Randomized and directed bench for reduction_stream_acc against a packet-level reference model.
// Latency: model expects result one cycle after the closing beat.
// Backpressure: out_ready driven directly or randomly; model predicts in_ready.
module tb_reduction_stream_acc;
   localparam int W     = 8;
   localparam int MAXW  = 4;
   localparam int CW    = $clog2(MAXW + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_last = 1'b0;
   logic [2:0]    mode = 3'd0;
   logic          out_valid;
   logic          out_ready;
   logic          out_result;
   logic [CW-1:0] out_words;
   logic          out_ovf;
   logic          out_err;

   logic          rnd_rdy = 1'b0;
   logic          rnd_val = 1'b0;
   logic          dir_rdy = 1'b1;
   assign out_ready = rnd_rdy ? rnd_val : dir_rdy;

   int n_chk  = 0;
   int n_fail = 0;

   reduction_stream_acc #(.WIDTH(W), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_words(out_words), .out_ovf(out_ovf), .out_err(out_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 rnd_val = ($urandom % 3) != 0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (packet level) ----------------
   bit [W-1:0] pq[$];
   bit [2:0]   m_mode;
   bit         m_valid, m_res, m_ovf, m_err;
   int         m_words;

   function automatic bit reduce_packet(input bit [2:0] m);
      bit all_ones = 1'b1;
      bit any_set  = 1'b0;
      int ones     = 0;
      bit base;
      foreach (pq[i]) begin
         if (pq[i] != {W{1'b1}}) all_ones = 1'b0;
         if (pq[i] != 0)         any_set  = 1'b1;
         ones += $countones(pq[i]);
      end
      if (m == 3'd0 || m == 3'd3)      base = all_ones;
      else if (m == 3'd2 || m == 3'd5) base = (ones % 2) == 1;
      else                             base = any_set;
      return (m >= 3'd3 && m <= 3'd5) ? !base : base;
   endfunction

   always @(negedge clk) begin
      bit acc;
      if (!rst_n) begin
         pq.delete();
         m_valid = 0; m_res = 0; m_words = 0; m_ovf = 0; m_err = 0; m_mode = 0;
      end
      check("out_valid",  {31'd0, out_valid},  {31'd0, m_valid});
      check("in_ready",   {31'd0, in_ready},   {31'd0, (!m_valid || out_ready)});
      check("out_result", {31'd0, out_result}, {31'd0, m_res});
      check("out_words",  32'(out_words),      32'(m_words));
      check("out_ovf",    {31'd0, out_ovf},    {31'd0, m_ovf});
      check("out_err",    {31'd0, out_err},    {31'd0, m_err});
      acc = rst_n && in_valid && (!m_valid || out_ready);
      if (rst_n && m_valid && out_ready) m_valid = 0;
      if (acc) begin
         if (pq.size() == 0) m_mode = mode;
         pq.push_back(in_data);
         if (in_last || pq.size() == MAXW) begin
            m_valid = 1;
            m_res   = reduce_packet(m_mode);
            m_words = pq.size();
            m_ovf   = !in_last;
            m_err   = (m_mode >= 3'd6);
            pq.delete();
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic beat(input logic [W-1:0] d, input logic l, input logic [2:0] m);
      bit got = 0;
      int n = 0;
      in_valid = 1'b1; in_data = d; in_last = l; mode = m;
      while (!got && n < 50) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check("beat_accept", {31'd0, got}, 32'd1);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic r, input int w, input logic o, input logic e);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      check({tag, "_valid"},  {31'd0, out_valid},  32'd1);
      check({tag, "_result"}, {31'd0, out_result}, {31'd0, r});
      check({tag, "_words"},  32'(out_words),      32'(w));
      check({tag, "_ovf"},    {31'd0, out_ovf},    {31'd0, o});
      check({tag, "_err"},    {31'd0, out_err},    {31'd0, e});
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // AND all ones
      beat(8'hFF, 0, 3'd0); beat(8'hFF, 0, 3'd0); beat(8'hFF, 1, 3'd0);
      wait_result("and3", 1, 3, 0, 0);
      // NAND and AND of FF,7F
      beat(8'hFF, 0, 3'd3); beat(8'h7F, 1, 3'd0);
      wait_result("nand", 1, 2, 0, 0);
      beat(8'hFF, 0, 3'd0); beat(8'h7F, 1, 3'd3);
      wait_result("and2", 0, 2, 0, 0);
      // XOR / XNOR of parities 1,0,1
      beat(8'h01, 0, 3'd2); beat(8'h03, 0, 3'd0); beat(8'h07, 1, 3'd0);
      wait_result("xor", 0, 3, 0, 0);
      beat(8'h01, 0, 3'd5); beat(8'h03, 0, 3'd0); beat(8'h07, 1, 3'd0);
      wait_result("xnor", 1, 3, 0, 0);
      // forced close at MAX_WORDS, then a new packet with re-latched mode
      repeat (4) beat(8'h00, 0, 3'd1);
      wait_result("ovf", 0, 4, 1, 0);
      beat(8'h01, 0, 3'd2); beat(8'h01, 1, 3'd1);
      wait_result("after_ovf", 0, 2, 0, 0);
      // last beat exactly at MAX_WORDS is not an overflow
      beat(8'h10, 0, 3'd1); beat(8'h00, 0, 3'd1); beat(8'h00, 0, 3'd1); beat(8'h00, 1, 3'd1);
      wait_result("full_last", 1, 4, 0, 0);

      // held result under backpressure, then retire + load on the same edge
      dir_rdy = 1'b0;
      beat(8'hFF, 1, 3'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid",  {31'd0, out_valid},  32'd1);
         check("hold_ready",  {31'd0, in_ready},   32'd0);
         check("hold_result", {31'd0, out_result}, 32'd1);
         check("hold_words",  32'(out_words),      32'd1);
      end
      @(posedge clk);
      #1;
      dir_rdy = 1'b1;
      beat(8'h00, 1, 3'd0);
      @(negedge clk);
      check("b2b_valid",  {31'd0, out_valid},  32'd1);
      check("b2b_result", {31'd0, out_result}, 32'd0);
      @(posedge clk);
      #1;

      // illegal mode folds as OR with error flag
      beat(8'h00, 0, 3'd6); beat(8'h01, 1, 3'd0);
      wait_result("illegal", 1, 2, 0, 1);

      // reset in the middle of a packet
      beat(8'hFF, 0, 3'd1); beat(8'hFF, 0, 3'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_valid",  {31'd0, out_valid},  32'd0);
      check("mrst_err",    {31'd0, out_err},    32'd0);
      check("mrst_result", {31'd0, out_result}, 32'd0);
      check("mrst_words",  32'(out_words),      32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      beat(8'hFE, 1, 3'd0);
      wait_result("post_rst", 0, 1, 0, 0);

      // randomized packets with random consumer stalls
      rnd_rdy = 1'b1;
      for (int p = 0; p < 300; p++) begin
         int len;
         logic [2:0] m;
         len = $urandom_range(1, 6);
         m   = 3'($urandom_range(0, 7));
         for (int w = 0; w < len; w++) begin
            logic [W-1:0] d;
            case ($urandom % 4)
               0:       d = 8'hFF;
               1:       d = 8'h00;
               default: d = 8'($urandom);
            endcase
            repeat ($urandom % 3) begin
               @(posedge clk);
               #1;
            end
            beat(d, w == len - 1, (w == 0) ? m : 3'($urandom % 8));
         end
      end
      rnd_rdy = 1'b0;
      dir_rdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
